// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible display-side responder for an 8-bit, 2-line LCD bus.
// Samples the asynchronous rs/rw/enable/data bus, decodes write strobes,
// and maintains DDRAM (80 B), CGRAM (64 x 5 bit) and the address counter.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rs, rw, enable, data       LCD bus from the controller (enable is asynchronous)
//   busy                       executing; strobes arriving while busy are dropped
//   cmd_strobe                 1-cycle pulse per accepted write
//   overrun, addr_err          sticky error flags
//   addr_counter, cg_mode      AC and its target RAM
//   entry_inc, display_on, cursor_on, blink_on, func_set   display state
//   dbg_dd_addr/dbg_dd_data    registered DDRAM read port (linear index 0-79)
//   dbg_cg_addr/dbg_cg_data    registered CGRAM read port
module lcd_hd44780_responder #(
   parameter int unsigned BUSY_CYCLES = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rs,
   input  logic       rw,
   input  logic       enable,
   input  logic [7:0] data,
   output logic       busy,
   output logic       cmd_strobe,
   output logic       overrun,
   output logic       addr_err,
   output logic [6:0] addr_counter,
   output logic       cg_mode,
   output logic       entry_inc,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic [2:0] func_set,
   input  logic [6:0] dbg_dd_addr,
   output logic [7:0] dbg_dd_data,
   input  logic [5:0] dbg_cg_addr,
   output logic [4:0] dbg_cg_data
);

   localparam int unsigned DD_SIZE  = 80;
   localparam int unsigned CG_SIZE  = 64;
   localparam int unsigned LINE_LEN = 40;
   localparam int unsigned BUS_W    = 11;
   localparam int unsigned CNT_W    = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
   localparam logic [6:0]  LAST_IDX = 7'(DD_SIZE - 1);
   localparam logic [7:0]  BLANK    = 8'h20;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_EXEC,
      ST_CLEAR,
      ST_BUSY_WAIT
   } state_t;

   // AC step with HD44780 line wrap in DDRAM, plain modular in CGRAM
   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic cg, input logic up);
      logic [6:0] r;
      if (cg) begin
         r = up ? {1'b0, a[5:0] + 6'd1} : {1'b0, a[5:0] - 6'd1};
      end else if (up) begin
         if (a == 7'h27)      r = 7'h40;
         else if (a == 7'h67) r = 7'h00;
         else                 r = a + 7'd1;
      end else begin
         if (a == 7'h00)      r = 7'h67;
         else if (a == 7'h40) r = 7'h27;
         else                 r = a - 7'd1;
      end
      return r;
   endfunction

   function automatic logic dd_valid(input logic [6:0] a);
      return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
   endfunction

   // DDRAM address to linear storage index: line 2 starts at 40
   function automatic logic [6:0] dd_map(input logic [6:0] a);
      return a[6] ? (7'(LINE_LEN) + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
   endfunction

   // Bus synchronizer; rs/rw/data travel with enable so they line up at the edge
   logic [BUS_W-1:0] bus_sync [SYNC_STAGES];
   logic             en_prev;
   logic             en_s, rw_s, rs_s;
   logic [7:0]       data_s;
   logic             wr_strobe_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) bus_sync[i] <= '0;
         en_prev <= 1'b0;
      end else begin
         bus_sync[0] <= {enable, rw, rs, data};
         for (int i = 1; i < int'(SYNC_STAGES); i++) bus_sync[i] <= bus_sync[i-1];
         en_prev <= bus_sync[SYNC_STAGES-1][10];
      end
   end

   assign en_s        = bus_sync[SYNC_STAGES-1][10];
   assign rw_s        = bus_sync[SYNC_STAGES-1][9];
   assign rs_s        = bus_sync[SYNC_STAGES-1][8];
   assign data_s      = bus_sync[SYNC_STAGES-1][7:0];
   assign wr_strobe_c = en_prev & ~en_s & ~rw_s;

   state_t           state, state_n;
   logic [6:0]       idx, idx_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [6:0]       ac_n;
   logic             cg_mode_n, entry_inc_n, display_on_n, cursor_on_n, blink_on_n;
   logic [2:0]       func_set_n;
   logic             busy_n, cmd_strobe_n, overrun_n, addr_err_n;
   logic             cmd_rs, cmd_rs_n;
   logic [7:0]       cmd_data, cmd_data_n;

   logic             dd_we_c, cg_we_c;
   logic [6:0]       dd_wa_c;
   logic [7:0]       dd_wd_c;
   logic [5:0]       cg_wa_c;
   logic [4:0]       cg_wd_c;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_INIT;
         idx          <= '0;
         cnt          <= '0;
         addr_counter <= '0;
         cg_mode      <= 1'b0;
         entry_inc    <= 1'b1;
         display_on   <= 1'b0;
         cursor_on    <= 1'b0;
         blink_on     <= 1'b0;
         func_set     <= 3'b000;
         busy         <= 1'b0;
         cmd_strobe   <= 1'b0;
         overrun      <= 1'b0;
         addr_err     <= 1'b0;
         cmd_rs       <= 1'b0;
         cmd_data     <= '0;
      end else begin
         state        <= state_n;
         idx          <= idx_n;
         cnt          <= cnt_n;
         addr_counter <= ac_n;
         cg_mode      <= cg_mode_n;
         entry_inc    <= entry_inc_n;
         display_on   <= display_on_n;
         cursor_on    <= cursor_on_n;
         blink_on     <= blink_on_n;
         func_set     <= func_set_n;
         busy         <= busy_n;
         cmd_strobe   <= cmd_strobe_n;
         overrun      <= overrun_n;
         addr_err     <= addr_err_n;
         cmd_rs       <= cmd_rs_n;
         cmd_data     <= cmd_data_n;
      end
   end

   // Next-state, command decode and RAM write control
   always_comb begin
      state_n      = state;
      idx_n        = idx;
      cnt_n        = cnt;
      ac_n         = addr_counter;
      cg_mode_n    = cg_mode;
      entry_inc_n  = entry_inc;
      display_on_n = display_on;
      cursor_on_n  = cursor_on;
      blink_on_n   = blink_on;
      func_set_n   = func_set;
      cmd_strobe_n = 1'b0;
      overrun_n    = overrun;
      addr_err_n   = addr_err;
      cmd_rs_n     = cmd_rs;
      cmd_data_n   = cmd_data;
      dd_we_c      = 1'b0;
      dd_wa_c      = idx;
      dd_wd_c      = BLANK;
      cg_we_c      = 1'b0;
      cg_wa_c      = addr_counter[5:0];
      cg_wd_c      = cmd_data[4:0];

      if (wr_strobe_c && (state != ST_IDLE)) overrun_n = 1'b1;

      case (state)
         ST_INIT: begin
            idx_n   = '0;
            state_n = ST_CLEAR;
         end
         ST_IDLE: begin
            if (wr_strobe_c) begin
               state_n      = ST_EXEC;
               cmd_rs_n     = rs_s;
               cmd_data_n   = data_s;
               cmd_strobe_n = 1'b1;
            end
         end
         ST_EXEC: begin
            state_n = ST_BUSY_WAIT;
            cnt_n   = '0;
            if (cmd_rs) begin
               if (cg_mode) begin
                  cg_we_c = 1'b1;
               end else begin
                  dd_we_c = 1'b1;
                  dd_wa_c = dd_map(addr_counter);
                  dd_wd_c = cmd_data;
               end
               ac_n = ac_step(addr_counter, cg_mode, entry_inc);
            end else begin
               casez (cmd_data)
                  8'b1???_????: begin
                     if (dd_valid(cmd_data[6:0])) begin
                        ac_n      = cmd_data[6:0];
                        cg_mode_n = 1'b0;
                     end else begin
                        addr_err_n = 1'b1;
                     end
                  end
                  8'b01??_????: begin
                     ac_n      = {1'b0, cmd_data[5:0]};
                     cg_mode_n = 1'b1;
                  end
                  8'b001?_????: func_set_n = cmd_data[4:2];
                  8'b0001_????: begin
                     if (!cmd_data[3]) ac_n = ac_step(addr_counter, cg_mode, cmd_data[2]);
                  end
                  8'b0000_1???: {display_on_n, cursor_on_n, blink_on_n} = cmd_data[2:0];
                  8'b0000_01??: entry_inc_n = cmd_data[1];
                  8'b0000_001?: begin
                     ac_n      = '0;
                     cg_mode_n = 1'b0;
                  end
                  8'b0000_0001: begin
                     ac_n        = '0;
                     cg_mode_n   = 1'b0;
                     entry_inc_n = 1'b1;
                     idx_n       = '0;
                     state_n     = ST_CLEAR;
                  end
                  default: ;
               endcase
            end
         end
         ST_CLEAR: begin
            dd_we_c = 1'b1;
            if (idx == LAST_IDX) begin
               state_n = ST_BUSY_WAIT;
               cnt_n   = '0;
            end else begin
               idx_n = idx + 7'd1;
            end
         end
         ST_BUSY_WAIT: begin
            if (cnt == CNT_W'(BUSY_CYCLES - 1)) state_n = ST_IDLE;
            else                                cnt_n   = cnt + CNT_W'(1);
         end
         default: state_n = ST_INIT;
      endcase

      busy_n = (state_n != ST_IDLE);
   end

   logic [7:0] ddram [DD_SIZE];
   logic [4:0] cgram [CG_SIZE];

   // RAM write ports (contents are not reset; DDRAM is blanked by the clear sequence)
   always_ff @(posedge clk) begin
      if (dd_we_c && !reset) ddram[dd_wa_c] <= dd_wd_c;
      if (cg_we_c && !reset) cgram[cg_wa_c] <= cg_wd_c;
   end

   // Debug read ports; a same-cycle write is seen on the following read
   always_ff @(posedge clk) begin
      if (reset) begin
         dbg_dd_data <= '0;
         dbg_cg_data <= '0;
      end else begin
         dbg_dd_data <= (dbg_dd_addr <= LAST_IDX) ? ddram[dbg_dd_addr] : BLANK;
         dbg_cg_data <= cgram[dbg_cg_addr];
      end
   end

endmodule
